hazard_ctrl: RTL and testbench

// Pipeline hazard and sequencing controller for the 5-stage core. Drives ForwardAE/ForwardBE for the

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Computes execute-stage forwarding selects, resolves load-use and
// branch/jump hazards, and freezes the front of the pipe while a
// multi-cycle MUL/DIV operation runs. Also keeps a saturating count
// of stalled fetch cycles.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic [4:0]       id_ex_rs1_idx,
  input  logic [4:0]       id_ex_rs2_idx,
  input  logic [4:0]       id_ex_rd_idx,
  input  logic             id_ex_MemRead,
  input  logic             id_ex_MulDiv,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_RegWrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_RegWrite,
  input  logic             PCSrc,
  input  logic             md_done,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ex_mem_kill,
  output logic             md_start,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cycles
);

  // Timer must be able to hold MD_TIMEOUT itself.
  localparam int TMR_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               md_error_q, md_error_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               load_use;

  // Forwarding selects: the younger producer (EX/MEM) wins over WB; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (ex_mem_RegWrite && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1_idx)
      ForwardAE = 2'b10;
    else if (mem_wb_RegWrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1_idx)
      ForwardAE = 2'b01;
    if (ex_mem_RegWrite && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2_idx)
      ForwardBE = 2'b10;
    else if (mem_wb_RegWrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2_idx)
      ForwardBE = 2'b01;
  end

  assign load_use = id_ex_MemRead && (id_ex_rd_idx != 5'd0) &&
                    ((id_ex_rd_idx == id_rs1_idx) || (id_ex_rd_idx == id_rs2_idx));

  // Next-state and control outputs from current state plus pipeline inputs.
  always_comb begin
    // NOTE: every output and next-state value gets a default up front so no
    // path through the case leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    md_error_d  = md_error_q;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    ex_mem_kill = 1'b0;
    md_start    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (PCSrc) begin
          // Redirect squashes decode and execute; any load-use is moot.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (id_ex_MulDiv) begin
          md_start    = 1'b1;
          StallF      = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          ex_mem_kill = 1'b1;
          timer_d     = TMR_W'(1);
          state_d     = MD_BUSY;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end

      MD_BUSY: begin
        // PCSrc is ignored: the branch sits behind the frozen MUL/DIV.
        StallF      = 1'b1;
        StallD      = 1'b1;
        StallE      = 1'b1;
        ex_mem_kill = 1'b1;
        if (md_done) begin
          state_d = MD_WB;
        end else if (timer_q == TMR_W'(MD_TIMEOUT)) begin
          md_error_d = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      MD_WB: begin
        // One free cycle lets the result move into EX/MEM before ID/EX advances.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Held in reset, the pipeline sees no stalls, flushes or starts.
    if (reset) begin
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      ex_mem_kill = 1'b0;
      md_start    = 1'b0;
    end

    stall_cycles_d = (StallF && stall_cycles_q != {CNT_W{1'b1}})
                   ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  end

  // State, timer, sticky error and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      md_error_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      md_error_q     <= md_error_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_error     = md_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives one cycle of inputs,
// pushes the expected outputs to a scoreboard queue and compares them
// against the DUT half a cycle later. A small counter model tracks the
// saturating stall count.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef logic [10:0] ctrl_t;                 // {fa, fb, sf, sd, se, fd, fe, kill, start}
  typedef logic [11+1+CNT_W-1:0] exp_t;        // {ctrl, md_error, stall_cycles}

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1_idx, id_rs2_idx, id_ex_rs1_idx, id_ex_rs2_idx, id_ex_rd_idx;
  logic             id_ex_MemRead, id_ex_MulDiv;
  logic [4:0]       ex_mem_rd, mem_wb_rd;
  logic             ex_mem_RegWrite, mem_wb_RegWrite, PCSrc, md_done;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, ex_mem_kill, md_start, md_error;
  logic [CNT_W-1:0] stall_cycles;

  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  exp_t             sb_q[$];
  ctrl_t            c_none, c_lu, c_br, c_mdi, c_mdb;

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_ex_rs1_idx(id_ex_rs1_idx), .id_ex_rs2_idx(id_ex_rs2_idx),
    .id_ex_rd_idx(id_ex_rd_idx), .id_ex_MemRead(id_ex_MemRead),
    .id_ex_MulDiv(id_ex_MulDiv), .ex_mem_rd(ex_mem_rd),
    .ex_mem_RegWrite(ex_mem_RegWrite), .mem_wb_rd(mem_wb_rd),
    .mem_wb_RegWrite(mem_wb_RegWrite), .PCSrc(PCSrc), .md_done(md_done),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .ex_mem_kill(ex_mem_kill),
    .md_start(md_start), .md_error(md_error), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t mk(input logic [1:0] fa, input logic [1:0] fb,
                               input logic sf, input logic sd, input logic se,
                               input logic fd, input logic fe,
                               input logic kill, input logic st);
    return {fa, fb, sf, sd, se, fd, fe, kill, st};
  endfunction

  task automatic clear_inputs();
    id_rs1_idx = '0; id_rs2_idx = '0; id_ex_rs1_idx = '0; id_ex_rs2_idx = '0;
    id_ex_rd_idx = '0; id_ex_MemRead = 1'b0; id_ex_MulDiv = 1'b0;
    ex_mem_rd = '0; ex_mem_RegWrite = 1'b0; mem_wb_rd = '0; mem_wb_RegWrite = 1'b0;
    PCSrc = 1'b0; md_done = 1'b0;
  endtask

  // One cycle: expectation in, compare mid-cycle, clock edge, update count model.
  task automatic step(input string tag, input ctrl_t ctrl, input logic err);
    exp_t e, o;
    sb_q.push_back({ctrl, err, exp_cnt});
    #1;
    o = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
         ex_mem_kill, md_start, md_error, stall_cycles};
    e = sb_q.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    @(posedge clk);
    if (reset) exp_cnt = '0;
    else if (ctrl[6] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    c_none = '0;
    c_lu   = mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0);
    c_br   = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0);
    c_mdi  = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1);
    c_mdb  = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0);

    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step("reset_state", c_none, 1'b0);
    reset = 1'b0;

    // Forwarding: EX/MEM beats WB, WB alone, x0 never forwards, mixed sources.
    ex_mem_rd = 5'd5; ex_mem_RegWrite = 1'b1; mem_wb_rd = 5'd5; mem_wb_RegWrite = 1'b1;
    id_ex_rs1_idx = 5'd5; id_ex_rs2_idx = 5'd5;
    step("fwd_exmem", mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    ex_mem_RegWrite = 1'b0;
    step("fwd_wb", mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
    id_ex_rs1_idx = 5'd0; id_ex_rs2_idx = 5'd0;
    step("fwd_x0", c_none, 1'b0);
    ex_mem_rd = 5'd3; mem_wb_rd = 5'd5; id_ex_rs1_idx = 5'd5; id_ex_rs2_idx = 5'd3;
    step("fwd_mixed", mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    clear_inputs();

    // Load-use: single hazard, then held hazard, then rd=x0 which is no hazard.
    id_ex_MemRead = 1'b1; id_ex_rd_idx = 5'd7; id_rs2_idx = 5'd7;
    step("lu_rs2", c_lu, 1'b0);
    clear_inputs();
    step("lu_clear", c_none, 1'b0);
    id_ex_MemRead = 1'b1; id_ex_rd_idx = 5'd9; id_rs1_idx = 5'd9;
    step("lu_hold0", c_lu, 1'b0);
    step("lu_hold1", c_lu, 1'b0);
    id_ex_rd_idx = 5'd0; id_rs1_idx = 5'd0;
    step("lu_x0", c_none, 1'b0);

    // Branch wins over a simultaneous load-use.
    id_ex_rd_idx = 5'd7; id_rs2_idx = 5'd7; PCSrc = 1'b1;
    step("br_over_lu", c_br, 1'b0);
    clear_inputs();

    // MUL/DIV with md_done four cycles after start; PCSrc ignored while busy.
    id_ex_MulDiv = 1'b1;
    step("md_issue", c_mdi, 1'b0);
    PCSrc = 1'b1;
    for (int i = 1; i <= 3; i++) step("md_busy", c_mdb, 1'b0);
    md_done = 1'b1;
    step("md_done", c_mdb, 1'b0);
    md_done = 1'b0; PCSrc = 1'b0;
    step("md_wb", c_none, 1'b0);
    id_ex_MulDiv = 1'b0; md_done = 1'b1;
    step("md_done_idle", c_none, 1'b0);
    md_done = 1'b0;

    // md_done arriving on the timeout cycle wins: no error.
    id_ex_MulDiv = 1'b1;
    step("tie_issue", c_mdi, 1'b0);
    for (int i = 1; i < MD_TIMEOUT; i++) step("tie_busy", c_mdb, 1'b0);
    md_done = 1'b1;
    step("tie_done", c_mdb, 1'b0);
    md_done = 1'b0;
    step("tie_wb", c_none, 1'b0);
    id_ex_MulDiv = 1'b0;
    step("tie_after", c_none, 1'b0);

    // Timeout twice: sticky error, stall drops, counter saturates.
    for (int r = 0; r < 2; r++) begin
      id_ex_MulDiv = 1'b1;
      step("to_issue", c_mdi, r != 0);
      for (int i = 1; i <= MD_TIMEOUT; i++) step("to_busy", c_mdb, r != 0);
      id_ex_MulDiv = 1'b0;
      step("to_idle", c_none, 1'b1);
    end

    // Reset while busy: next cycle idle, error and counter cleared.
    id_ex_MulDiv = 1'b1;
    step("rst_issue", c_mdi, 1'b1);
    step("rst_busy", c_mdb, 1'b1);
    pulse_reset();
    clear_inputs();
    step("rst_after", c_none, 1'b0);
    step("rst_after2", c_none, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
